// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, control-step state encoding and
// the control-strobe bundle driven by the control unit onto the DataPath.
package cpu_pkg;

  localparam int STEP_W = 4;
  localparam int OP_W   = 5;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;
  localparam opcode_t OP_IDLE = 5'b00000;

  typedef enum logic [STEP_W-1:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_IMM,
    CLS_LD,
    CLS_ST,
    CLS_JR,
    CLS_MF,
    CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic read;
    logic write;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic hi_out;
    logic lo_out;
    logic hi_in;
    logic lo_in;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Maps an instruction opcode onto the execution class that selects the
// T3..T7 micro-sequence; anything unrecognised falls into the nop class.
module control_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_t       op_class,
  output logic            mf_lo
);

  always_comb begin
    op_class = CLS_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_ALU;
      OP_ADDI:                       op_class = CLS_IMM;
      OP_LD:                         op_class = CLS_LD;
      OP_ST:                         op_class = CLS_ST;
      OP_JR:                         op_class = CLS_JR;
      OP_MFHI, OP_MFLO:              op_class = CLS_MF;
      OP_HALT:                       op_class = CLS_HALT;
      default:                       op_class = CLS_NOP;
    endcase
  end

  assign mf_lo = (op == OP_MFLO);

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer: fetch in T0..T2, class-specific execute steps in
// T3..T7, with a sticky HALT state left only through reset.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        HIout,
  output logic        LOout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  opcode,
  output logic        run
);

  state_t    state_reg;
  state_t    state_next;
  state_t    done_state;
  op_class_t op_class;
  opcode_t   ir_op;
  logic      mf_lo;
  ctrl_t     ctrl;
  logic      unused_ir;

  assign ir_op     = ir[31:27];
  assign unused_ir = ^ir[26:0];

  control_decode u_decode (
    .op       (ir_op),
    .op_class (op_class),
    .mf_lo    (mf_lo)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_reg <= ST_RESET;
    else        state_reg <= state_next;
  end

  // Final step of every instruction funnels through here so stop is honoured uniformly.
  assign done_state = stop ? ST_HALT : ST_T0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = ST_T0;
      ST_T0:    state_next = ST_T1;
      ST_T1:    state_next = ST_T2;
      ST_T2:    state_next = (op_class == CLS_NOP) ? done_state : ST_T3;
      ST_T3: begin
        case (op_class)
          CLS_ALU, CLS_IMM, CLS_LD, CLS_ST: state_next = ST_T4;
          CLS_HALT:                         state_next = ST_HALT;
          default:                          state_next = done_state;
        endcase
      end
      ST_T4:    state_next = ST_T5;
      ST_T5:    state_next = (op_class == CLS_LD || op_class == CLS_ST) ? ST_T6 : done_state;
      ST_T6:    state_next = ST_T7;
      ST_T7:    state_next = done_state;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_RESET;
    endcase
  end

  always_comb begin
    ctrl   = '0;
    opcode = OP_IDLE;
    run    = (state_reg != ST_RESET) && (state_reg != ST_HALT);
    case (state_reg)
      ST_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
      end
      ST_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          CLS_ALU, CLS_IMM: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
          end
          CLS_JR: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
          end
          CLS_MF: begin
            ctrl.hi_out = !mf_lo; ctrl.lo_out = mf_lo; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CLS_ALU: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; opcode = ir_op;
          end
          CLS_IMM, CLS_LD, CLS_ST: begin
            ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; opcode = OP_ADD;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class)
          CLS_ALU, CLS_IMM: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (op_class == CLS_ST) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
        end else begin
          ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        end
      end
      ST_T7: begin
        if (op_class == CLS_ST) begin
          ctrl.write = 1'b1;
        end else begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PCout    = ctrl.pc_out;
  assign PCin     = ctrl.pc_in;
  assign IncPC    = ctrl.inc_pc;
  assign MARin    = ctrl.mar_in;
  assign MDRin    = ctrl.mdr_in;
  assign MDRout   = ctrl.mdr_out;
  assign IRin     = ctrl.ir_in;
  assign Read     = ctrl.read;
  assign Write    = ctrl.write;
  assign Yin      = ctrl.y_in;
  assign Zin      = ctrl.z_in;
  assign Zlowout  = ctrl.zlow_out;
  assign Zhighout = ctrl.zhigh_out;
  assign Gra      = ctrl.gra;
  assign Grb      = ctrl.grb;
  assign Grc      = ctrl.grc;
  assign Rin      = ctrl.r_in;
  assign Rout     = ctrl.r_out;
  assign BAout    = ctrl.ba_out;
  assign Cout     = ctrl.c_out;
  assign HIout    = ctrl.hi_out;
  assign LOout    = ctrl.lo_out;
  assign HIin     = ctrl.hi_in;
  assign LOin     = ctrl.lo_in;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction table, random instruction stream checked
// against a micro-op list model, plus stop/halt and mid-instruction reset cases.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        stop;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write, Yin, Zin;
  logic Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIout, LOout, HIin, LOin;
  logic [4:0]  opcode;
  logic        run;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read), .Write(Write), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .HIout(HIout), .LOout(LOout),
    .HIin(HIin), .LOin(LOin), .opcode(opcode), .run(run)
  );

  always #5 clock = ~clock;

  localparam logic [23:0] PCOUT = 24'h800000, PCIN  = 24'h400000, INCPC = 24'h200000;
  localparam logic [23:0] MARIN = 24'h100000, MDRIN = 24'h080000, MDROUT = 24'h040000;
  localparam logic [23:0] IRIN  = 24'h020000, READ  = 24'h010000, WRITE = 24'h008000;
  localparam logic [23:0] YIN   = 24'h004000, ZIN   = 24'h002000, ZLOW  = 24'h001000;
  localparam logic [23:0] ZHIGH = 24'h000800, GRA   = 24'h000400, GRB   = 24'h000200;
  localparam logic [23:0] GRC   = 24'h000100, RIN   = 24'h000080, ROUT  = 24'h000040;
  localparam logic [23:0] BAOUT = 24'h000020, COUT  = 24'h000010, HIOUT = 24'h000008;
  localparam logic [23:0] LOOUT = 24'h000004, HIIN  = 24'h000002, LOIN  = 24'h000001;
  localparam logic [23:0] DRIVERS = PCOUT | MDROUT | ZLOW | ZHIGH | ROUT | BAOUT | COUT | HIOUT | LOOUT;

  logic [23:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write, Yin, Zin,
                Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIout, LOout, HIin, LOin};

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] exp_w[$];
  logic [4:0]  exp_op[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic [23:0] w, input logic [4:0] op);
    exp_w.push_back(w);
    exp_op.push_back(op);
  endfunction

  // Reference: the instruction's micro-op list, fetch steps first.
  function automatic void model(input logic [4:0] op);
    exp_w = {};
    exp_op = {};
    push(PCOUT | MARIN | INCPC | ZIN, 5'd0);
    push(ZLOW | PCIN | READ | MDRIN, 5'd0);
    push(MDROUT | IRIN, 5'd0);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(GRB | ROUT | YIN, 5'd0); push(GRC | ROUT | ZIN, op); push(ZLOW | GRA | RIN, 5'd0);
      end
      5'b01100: begin
        push(GRB | ROUT | YIN, 5'd0); push(COUT | ZIN, 5'b00011); push(ZLOW | GRA | RIN, 5'd0);
      end
      5'b00000: begin
        push(GRB | BAOUT | YIN, 5'd0); push(COUT | ZIN, 5'b00011); push(ZLOW | MARIN, 5'd0);
        push(READ | MDRIN, 5'd0); push(MDROUT | GRA | RIN, 5'd0);
      end
      5'b00010: begin
        push(GRB | BAOUT | YIN, 5'd0); push(COUT | ZIN, 5'b00011); push(ZLOW | MARIN, 5'd0);
        push(GRA | ROUT | MDRIN, 5'd0); push(WRITE, 5'd0);
      end
      5'b10100: push(GRA | ROUT | PCIN, 5'd0);
      5'b11000: push(HIOUT | GRA | RIN, 5'd0);
      5'b11001: push(LOOUT | GRA | RIN, 5'd0);
      5'b11011: push(24'h0, 5'd0);
      default: ;
    endcase
  endfunction

  // Entered just after the edge that put the DUT into T0.
  task automatic run_instr(input string nm, input logic [31:0] ir_v, input bit stop_last,
                           input int exp_len);
    model(ir_v[31:27]);
    ir = ir_v;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge clock);
      chk($sformatf("%s step%0d ctrl", nm, i), {8'h0, obs},
          (i < exp_w.size()) ? {8'h0, exp_w[i]} : 32'h0);
      chk($sformatf("%s step%0d opcode", nm, i), {27'h0, opcode},
          (i < exp_op.size()) ? {27'h0, exp_op[i]} : 32'h0);
      chk($sformatf("%s step%0d run", nm, i), {31'h0, run}, 32'h1);
      chk($sformatf("%s step%0d exclusive", nm, i),
          {30'h0, Read & Write, ($countones(obs & DRIVERS) > 1)}, 32'h0);
      if (i == exp_len - 1 && stop_last) stop = 1'b1;
      @(posedge clock);
      #1 stop = 1'b0;
    end
    $display("instr %-8s ir=%h steps=%0d stop=%0d", nm, ir_v, exp_len, stop_last);
  endtask

  task automatic check_halted(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk($sformatf("%s cyc%0d ctrl", nm, i), {8'h0, obs}, 32'h0);
      chk($sformatf("%s cyc%0d run", nm, i), {31'h0, run}, 32'h0);
      chk($sformatf("%s cyc%0d opcode", nm, i), {27'h0, opcode}, 32'h0);
    end
    $display("idle   %-8s %0d cycles checked", nm, n);
  endtask

  task automatic release_reset();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          len;
  } vec_t;

  vec_t table_v[12];

  logic [4:0] known_ops[11];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    table_v[0]  = '{"add",   32'h1A200000, 6};
    table_v[1]  = '{"ld",    32'h00800075, 8};
    table_v[2]  = '{"st",    32'h10800075, 8};
    table_v[3]  = '{"jr",    32'hA1000000, 4};
    table_v[4]  = '{"sub",   32'h21234567, 6};
    table_v[5]  = '{"and",   32'h2A000001, 6};
    table_v[6]  = '{"or",    32'h33FFFFFF, 6};
    table_v[7]  = '{"addi",  32'h60880042, 6};
    table_v[8]  = '{"mfhi",  32'hC0800000, 4};
    table_v[9]  = '{"mflo",  32'hC8800000, 4};
    table_v[10] = '{"nop",   32'hD0000000, 3};
    table_v[11] = '{"undef", 32'h78000000, 3};
    known_ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                  5'b01100, 5'b10100, 5'b11000, 5'b11001, 5'b11010};

    clear = 1'b0;
    stop  = 1'b0;
    ir    = 32'h0;
    check_halted("reset", 3);
    release_reset();

    foreach (table_v[k]) run_instr(table_v[k].name, table_v[k].ir, 1'b0, table_v[k].len);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 3) != 0) op = known_ops[$urandom_range(0, 10)];
      else begin
        op = 5'($urandom_range(0, 31));
        if (op == 5'b11011) op = 5'b11111;
      end
      model(op);
      run_instr("random", {op, 27'($urandom)}, 1'b0, exp_w.size());
    end

    // stop raised during ALU T5: HALT on the next edge, held until reset
    run_instr("add_stop", 32'h1A200000, 1'b1, 6);
    check_halted("halted", 20);
    @(negedge clock);
    clear = 1'b0;
    #1 chk("clear in halt run", {31'h0, run}, 32'h0);
    release_reset();

    // reset asserted in the middle of ld T6
    run_instr("ld_part", 32'h00800075, 1'b0, 6);
    #1 chk("ld T6 ctrl", {8'h0, obs}, {8'h0, READ | MDRIN});
    clear = 1'b0;
    #1;
    chk("abort ctrl", {8'h0, obs}, 32'h0);
    chk("abort run", {31'h0, run}, 32'h0);
    chk("abort opcode", {27'h0, opcode}, 32'h0);
    check_halted("abort", 2);
    release_reset();
    run_instr("add", 32'h1A200000, 1'b0, 6);

    // halt instruction parks the unit after T3
    run_instr("halt", 32'hD8000000, 1'b0, 4);
    check_halted("haltop", 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  in  1  reset; asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: ir  in  32  DataPath IR contents; opcode = ir[31:27].
REQ-004 SHALL have port: stop  in  1  request halt at the next instruction boundary.
REQ-005 SHALL have ports, all out 1: PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write, Yin, Zin, Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIout, LOout, HIin, LOin (DataPath control strobes).
REQ-006 SHALL have port: opcode  out  5  ALU operation select to DataPath.
REQ-007 SHALL have port: run  out  1  1 while executing; 0 in RESET and HALT.

Function
REQ-008 SHALL be a Moore FSM: outputs decoded from the state register and ir only, one control step per clock.
REQ-009 SHALL implement states RESET, T0..T7, HALT.
REQ-010 SHALL assert in T0: PCout, MARin, IncPC, Zin.
REQ-011 SHALL assert in T1: Zlowout, PCin, Read, MDRin.
REQ-012 SHALL assert in T2: MDRout, IRin; decode uses ir from T3 onward.
REQ-013 SHALL execute add/sub/and/or (00011/00100/00101/00110) as: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, opcode=ir opcode; T5 Zlowout,Gra,Rin.
REQ-014 SHALL execute addi (01100) as: T3 Grb,Rout,Yin; T4 Cout,Zin, opcode=add; T5 Zlowout,Gra,Rin.
REQ-015 SHALL execute ld (00000) as: T3 Grb,BAout,Yin; T4 Cout,Zin, opcode=add; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-016 SHALL execute st (00010) as: T3–T5 identical to ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
REQ-017 SHALL execute jr (10100) as: T3 Gra,Rout,PCin.
REQ-018 SHALL execute mfhi (11000) / mflo (11001) as: T3 HIout/LOout,Gra,Rin.
REQ-019 SHALL treat nop (11010) and undefined opcodes as nop: T2 goes directly to T0.
REQ-020 SHALL enter HALT from T3 on halt (11011); HALT is exited only by reset.
REQ-021 SHALL transition from the last step of each instruction to T0, or to HALT if stop=1 at that clock edge.
REQ-022 SHALL hold opcode=00000 except in the T4 steps defined above; HIin, LOin, Zhighout SHALL remain 0.
REQ-023 SHALL complete instructions in these cycle counts from T0: nop 3, jr/mfhi/mflo 4, ALU/addi 6, ld/st 8.
REQ-024 SHALL never assert Read and Write, or two bus drivers (*out), in the same state.

Reset
REQ-025 SHALL, while clear=0, force state RESET, all outputs 0, and run=0, independent of clock.
REQ-026 SHALL abort any in-progress instruction immediately when reset is asserted mid-instruction.
REQ-027 SHALL enter T0 on the first rising edge after clear returns to 1.

Structure
REQ-028 SHALL take opcode encodings, the state enum, and step width from shared package cpu_pkg, which DataPath also uses.
REQ-029 SHALL place opcode-class decode (ALU, imm, ld, st, jr, mf, nop, halt) in sub-module control_decode; the FSM and output decode stay in control_unit.

Verification
REQ-030 Verification SHALL cover: clear=0 then release → all outputs 0 during reset; T0 on first edge; T0 asserts PCout/MARin/IncPC/Zin.
REQ-031 Verification SHALL cover: ir=0x1A200000 (add R4,R4,R0) → T3 Grb/Rout/Yin, T4 opcode=00011 with Zin, T5 Gra/Rin, T0 at cycle 7.
REQ-032 Verification SHALL cover: ld ir=0x00800075 → 8-cycle sequence per REQ-015; Read asserted only in T1 and T6.
REQ-033 Verification SHALL cover: st then jr ir=0xA1000000 → Write only in st T7; jr PCin in T3; next T0 one cycle later.
REQ-034 Verification SHALL cover: stop=1 during ALU T5 → HALT next edge, run=0, outputs frozen at 0 for 20 cycles.
REQ-035 Verification SHALL cover: clear=0 asserted mid-T6 of ld → outputs 0 within the same cycle; restart at T0 after release.
